// File: rtl/pipelined_ffs_stream.sv
// Pipelined find-first-set over a valid/ready stream.
// One binary-search halving stage per index bit; mode selects highest or lowest set bit.
module pipelined_ffs_stream #(
    parameter int WIDTH = 1024,
    parameter int TAG_W = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     valid_in,
    output logic                     ready_out,
    input  logic [WIDTH-1:0]         in,
    input  logic                     mode_in,
    input  logic [TAG_W-1:0]         tag_in,
    output logic                     valid_out,
    input  logic                     ready_in,
    output logic [$clog2(WIDTH)-1:0] index,
    output logic                     found,
    output logic [TAG_W-1:0]         tag_out
);
    localparam int L = $clog2(WIDTH);

    if (WIDTH < 2 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
        $error("pipelined_ffs_stream: WIDTH must be a power of two >= 2");
    end
    if (TAG_W < 1) begin : g_bad_tag
        $error("pipelined_ffs_stream: TAG_W must be >= 1");
    end

    logic             valid_out_d, valid_out_q;
    logic [L-1:0]     index_d, index_q;
    logic             found_d, found_q;
    logic [TAG_W-1:0] tag_out_d, tag_out_q;
    logic             stall;

    assign stall     = valid_out_q && !ready_in;
    assign ready_out = !stall && !reset;

    for (genvar k = 0; k < L; k++) begin : g_st
        localparam int W = WIDTH >> k;

        logic [W-1:0]     vec_d, vec_q;
        logic [L-1:0]     idx_d, idx_q, idx_nxt;
        logic             mode_d, mode_q;
        logic             found_d, found_q;
        logic             valid_d, valid_q;
        logic [TAG_W-1:0] tag_d, tag_q;
        logic             sel;

        if (k == 0) begin : g_head
            always_comb begin
                vec_d   = in;
                idx_d   = '0;
                mode_d  = mode_in;
                found_d = |in;
                tag_d   = tag_in;
                valid_d = valid_in && ready_out;
            end
        end else begin : g_body
            always_comb begin
                vec_d   = g_st[k-1].sel ? g_st[k-1].vec_q[2*W-1:W]
                                        : g_st[k-1].vec_q[W-1:0];
                idx_d   = g_st[k-1].idx_nxt;
                mode_d  = g_st[k-1].mode_q;
                found_d = g_st[k-1].found_q;
                tag_d   = g_st[k-1].tag_q;
                valid_d = g_st[k-1].valid_q;
            end
        end

        // sel is gated by found so an all-zero word always yields index 0
        always_comb begin
            sel = found_q && (mode_q ? (|vec_q[W-1:W/2]) : !(|vec_q[W/2-1:0]));
            idx_nxt = idx_q;
            idx_nxt[L-1-k] = sel;
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                valid_q <= 1'b0;
            end else if (!stall) begin
                valid_q <= valid_d;
                vec_q   <= vec_d;
                idx_q   <= idx_d;
                mode_q  <= mode_d;
                found_q <= found_d;
                tag_q   <= tag_d;
            end
        end
    end

    always_comb begin
        valid_out_d = g_st[L-1].valid_q;
        index_d     = g_st[L-1].idx_nxt;
        found_d     = g_st[L-1].found_q;
        tag_out_d   = g_st[L-1].tag_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_out_q <= 1'b0;
            index_q     <= '0;
            found_q     <= 1'b0;
            tag_out_q   <= '0;
        end else if (!stall) begin
            valid_out_q <= valid_out_d;
            index_q     <= index_d;
            found_q     <= found_d;
            tag_out_q   <= tag_out_d;
        end
    end

    assign valid_out = valid_out_q;
    assign index     = index_q;
    assign found     = found_q;
    assign tag_out   = tag_out_q;
endmodule
